// File: rtl/mem_stage_lmsm.sv
// Memory stage: single-cycle LW/SW plus one-access-per-cycle LM/SM sequencing with upstream stall.
// Optional MEM_WAIT_EN adds a mem_ready input that holds any access cycle until the memory accepts it.
module mem_stage_lmsm #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [5:0]    in_op,
  input  logic [2:0]    in_regA,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_sdata,
  input  logic [7:0]    in_list,
  input  logic [1:0]    in_ccr,
  output logic [2:0]    rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_WAIT_EN
  input  logic          mem_ready,
`endif
  output logic          stall,
  output logic          wb_valid,
  output logic [2:0]    wb_reg,
  output logic [DW-1:0] wb_data,
  output logic          ccr_we,
  output logic [1:0]    ccr_val,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LM_RUN = 2'd1, SM_RUN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [7:0]    list_q, list_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_lw_q, rd_lw_d;
  logic [2:0]    rd_reg_q, rd_reg_d;
  logic          carry_q, carry_d;

  logic          rdy;
  logic          do_seq, seq_sm;
  logic [7:0]    cur_list, rest;
  logic [AW-1:0] cur_addr;
  logic [2:0]    k;
  logic          unused_ok;

`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  assign unused_ok = ^{in_op[1:0], in_ccr[1]};

  // In IDLE the sequence is serviced straight from the ex_mem register.
  assign cur_list = (state_q == IDLE) ? in_list : list_q;
  assign cur_addr = (state_q == IDLE) ? in_addr : addr_q;
  assign rest     = cur_list & (cur_list - 8'd1);

  always_comb begin
    k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cur_list[i]) k = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    addr_d    = addr_q;
    rd_pend_d = 1'b0;
    rd_lw_d   = 1'b0;
    rd_reg_d  = 3'd0;
    carry_d   = carry_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rf_raddr  = 3'd0;
    stall     = 1'b0;
    do_seq    = 1'b0;
    seq_sm    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            unique case (in_op[5:2])
              4'b0100: begin
                mem_re   = 1'b1;
                mem_addr = in_addr;
                stall    = !rdy;
                if (rdy) begin
                  rd_pend_d = 1'b1;
                  rd_lw_d   = 1'b1;
                  rd_reg_d  = in_regA;
                  carry_d   = in_ccr[0];
                end
              end
              4'b0101: begin
                mem_we    = 1'b1;
                mem_addr  = in_addr;
                mem_wdata = in_sdata;
                stall     = !rdy;
              end
              4'b0110, 4'b0111: begin
                do_seq = (in_list != 8'd0);
                seq_sm = in_op[2];
              end
              default: ;
            endcase
          end
        end
        LM_RUN: do_seq = 1'b1;
        SM_RUN: begin
          do_seq = 1'b1;
          seq_sm = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (do_seq) begin
      mem_addr = cur_addr;
      if (seq_sm) begin
        mem_we    = 1'b1;
        rf_raddr  = k;
        mem_wdata = rf_rdata;
      end else begin
        mem_re = 1'b1;
      end
      // The final access of a sequence releases the pipeline in its own cycle.
      stall = !rdy || (rest != 8'd0);
      if (rdy) begin
        list_d = rest;
        addr_d = cur_addr + AW'(1);
        if (!seq_sm) begin
          rd_pend_d = 1'b1;
          rd_reg_d  = k;
        end
        if (rest == 8'd0) state_d = IDLE;
        else              state_d = seq_sm ? SM_RUN : LM_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      list_q    <= 8'd0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_lw_q   <= 1'b0;
      rd_reg_q  <= 3'd0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      rd_lw_q   <= rd_lw_d;
      rd_reg_q  <= rd_reg_d;
      carry_q   <= carry_d;
    end
  end

  // Read data arrives the cycle after the strobe, so write-back uses it directly.
  assign wb_valid  = rd_pend_q;
  assign wb_reg    = rd_reg_q;
  assign wb_data   = rd_pend_q ? mem_rdata : '0;
  assign ccr_we    = rd_lw_q;
  assign ccr_val   = rd_lw_q ? {(mem_rdata == '0), carry_q} : 2'b00;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_stage_lmsm.md
Name: mem_stage_lmsm

Overview:
- Memory stage of the 6-stage pipelined core; consumes the execute→memory pipeline register (ALU result, RA value, op, register fields).
- Performs LW/SW as single accesses and sequences LM/SM as one memory access per cycle, stalling upstream while doing so.
- Produces the registered write-back data, register index and CCR update (LW zero flag) that the write-back stage and the execute-stage forwarding mux consume.

Parameters:
- AW, 16, memory address width
- DW, 16, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  ex_mem register holds a live instruction
- in_op  in  6  {IR[15:12],IR[1:0]}; only [5:2] decoded (LW=0100, SW=0101, LM=0110, SM=0111)
- in_regA  in  3  destination reg for LW
- in_addr  in  AW  effective address (ALUOut) for LW/SW; base address for LM/SM
- in_sdata  in  DW  store data for SW (RAOut)
- in_list  in  8  LM/SM register list; bit i = Ri
- in_ccr  in  2  current {zero,carry}
- rf_raddr  out  3  register-file read index for SM
- rf_rdata  in  DW  combinational RF read data
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  DW  read data, valid the cycle after mem_re
- stall  out  1  hold fetch..execute and freeze ex_mem register
- wb_valid  out  1  wb_reg/wb_data valid, write RF
- wb_reg  out  3  destination register
- wb_data  out  DW  data to write
- ccr_we  out  1  write CCR
- ccr_val  out  2  {zero,carry}

Behaviour:
- Reset (synchronous, active-high): state IDLE; stall, mem_we, mem_re, wb_valid, ccr_we = 0; wb_reg, wb_data, mem_addr, mem_wdata, rf_raddr, ccr_val = 0; pending list and address cleared. Reset mid-LM/SM abandons the sequence; no further accesses are issued.
- States: IDLE, LM_RUN, SM_RUN.
- IDLE, in_valid=0 or non-memory op: no strobes, no stall.
- LW: mem_re=1 and mem_addr=in_addr combinationally in the accept cycle. Next cycle: wb_valid=1, wb_reg=in_regA (registered), wb_data=mem_rdata. Also ccr_we=1, ccr_val={mem_rdata==0, in_ccr[0] captured at accept}. Carry is preserved. No stall.
- SW: mem_we=1, mem_addr=in_addr, mem_wdata=in_sdata in the accept cycle. No wb, no CCR write, no stall.
- LM/SM accept in IDLE: latch list=in_list and addr=in_addr.
  - in_list==0: complete as a NOP with no stall.
  - Otherwise go to LM_RUN/SM_RUN. stall=1 combinationally in the accept cycle and every RUN cycle except the last access cycle.
- Each RUN cycle (including the accept cycle) services the lowest set bit k of the pending list:
  - LM: mem_re=1, mem_addr=addr. Next cycle wb_valid=1, wb_reg=k, wb_data=mem_rdata.
  - SM: rf_raddr=k, mem_we=1, mem_addr=addr, mem_wdata=rf_rdata.
  - Then clear bit k and set addr=addr+1, wrapping modulo 2^AW (0xFFFF→0x0000).
- When the pending list becomes empty, return to IDLE. That cycle stall=0, so the next instruction is accepted one cycle later.
- Access count equals popcount(in_list). Access addresses are base..base+n-1 in ascending register order.
- LM never writes CCR.
- LM wb and an LW wb never overlap because the stall blocks accept.
- in_valid is ignored while in RUN states; the ex_mem register is frozen.

Optional Feature:
- MEM_WAIT_EN.
  - Defined: adds input mem_ready (1 bit). Any access cycle with mem_ready=0 is held: strobes, address and data stay stable, list and addr do not advance, and stall=1 (including LW/SW in IDLE). Read data is taken the cycle after the cycle where mem_re && mem_ready.
  - Undefined: no port; memory is treated as always ready.

Test Plan:
- LW R3 from 0x0040, mem[0x40]=0x0000 → cycle+1: wb_valid=1, wb_reg=3, wb_data=0, ccr_we=1, ccr_val=2'b1c with c = captured carry.
- SW addr 0x0010, in_sdata=0xBEEF → same cycle: mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF; no wb, stall=0.
- LM list=8'b1000_0101, base 0x0100 → reads 0x100,0x101,0x102 in 3 consecutive cycles; wb_reg sequence 0,2,7; stall high exactly 2 cycles.
- SM list=8'hFF, base 0xFFFE → 8 writes at 0xFFFE,0xFFFF,0x0000..0x0005 with data R0..R7; stall 7 cycles.
- LM with list=0 → no strobes, no stall, no wb; reset asserted in the 2nd cycle of SM list=8'h0F → no further mem_we, all outputs 0 next cycle.
- (MEM_WAIT_EN) LW with mem_ready low for 2 cycles → mem_re held 3 cycles, stall=1 for 2 cycles, wb_valid one cycle after the ready cycle.
